// File: rtl/cerr_thresh_ctrl.sv
// Per-channel correctable-error counters with programmable sticky alarm thresholds.
// Thresholds are written through a vld/ack handshake: capture, then a one-cycle ack, then wait for vld low.
module cerr_thresh_ctrl #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned THR_W   = 8,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned DEF_THR = 0
) (
    input  logic                    bist_clk,
    input  logic                    reset_n,
    input  logic                    cerr_threshold_vld,
    input  logic [CH_W-1:0]         cerr_threshold_ch,
    input  logic [THR_W-1:0]        cerr_threshold,
    output logic                    cerr_threshold_ack,
    input  logic [NUM_CH-1:0]       cerr_evt,
    input  logic [NUM_CH-1:0]       cerr_clr,
    output logic [NUM_CH*THR_W-1:0] cerr_count,
    output logic [NUM_CH-1:0]       cerr_over,
    output logic                    cerr_irq
);

    typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

    state_e             state_q;
    logic               ack_q;
    logic [CH_W-1:0]    wr_ch_q;
    logic [THR_W-1:0]   wr_val_q;
    logic [THR_W-1:0]   thr_q   [NUM_CH];
    logic [THR_W-1:0]   count_q [NUM_CH];
    logic [THR_W-1:0]   count_d [NUM_CH];
    logic [NUM_CH-1:0]  over_q;
    logic [NUM_CH-1:0]  over_d;

    // Threshold lands one edge after capture; an out-of-range channel matches nothing.
    always_ff @(posedge bist_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ack_q    <= 1'b0;
            wr_ch_q  <= '0;
            wr_val_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                thr_q[i] <= THR_W'(DEF_THR);
            end
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cerr_threshold_vld) begin
                        wr_ch_q  <= cerr_threshold_ch;
                        wr_val_q <= cerr_threshold;
                        ack_q    <= 1'b1;
                        state_q  <= StAck;
                    end
                end
                StAck: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (wr_ch_q == CH_W'(i)) begin
                            thr_q[i] <= wr_val_q;
                        end
                    end
                    state_q <= StHold;
                end
                StHold: begin
                    if (!cerr_threshold_vld) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Alarm compares the post-update count against the currently active threshold.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            over_d[i]  = over_q[i];
            if (cerr_clr[i]) begin
                count_d[i] = '0;
                over_d[i]  = 1'b0;
            end else begin
                if (cerr_evt[i] && (count_q[i] != {THR_W{1'b1}})) begin
                    count_d[i] = count_q[i] + THR_W'(1);
                end
                if ((thr_q[i] != '0) && (count_d[i] >= thr_q[i])) begin
                    over_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge bist_clk or negedge reset_n) begin
        if (!reset_n) begin
            over_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            over_q <= over_d;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    always_comb begin
        cerr_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cerr_count[i*THR_W +: THR_W] = count_q[i];
        end
    end

    assign cerr_threshold_ack = ack_q;
    assign cerr_over          = over_q;
    assign cerr_irq           = |over_q;

endmodule

// File: tb/tb_cerr_thresh_ctrl.sv
// Bench for cerr_thresh_ctrl: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of counters, alarms and handshake.
module tb_cerr_thresh_ctrl;

    localparam int NCH   = 3;
    localparam int THR_W = 8;
    localparam int CH_W  = 2;
    localparam int MAXC  = (1 << THR_W) - 1;

    logic                   bist_clk = 1'b0;
    logic                   reset_n;
    logic                   vld = 1'b0;
    logic [CH_W-1:0]        ch  = '0;
    logic [THR_W-1:0]       val = '0;
    logic                   ack;
    logic [NCH-1:0]         evt = '0;
    logic [NCH-1:0]         clr = '0;
    logic [NCH*THR_W-1:0]   cnt;
    logic [NCH-1:0]         over;
    logic                   irq;

    int n_checks = 0;
    int n_errors = 0;

    cerr_thresh_ctrl #(
        .NUM_CH (NCH),
        .THR_W  (THR_W),
        .CH_W   (CH_W),
        .DEF_THR(0)
    ) dut (
        .bist_clk          (bist_clk),
        .reset_n           (reset_n),
        .cerr_threshold_vld(vld),
        .cerr_threshold_ch (ch),
        .cerr_threshold    (val),
        .cerr_threshold_ack(ack),
        .cerr_evt          (evt),
        .cerr_clr          (clr),
        .cerr_count        (cnt),
        .cerr_over         (over),
        .cerr_irq          (irq)
    );

    always #5 bist_clk = ~bist_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dcnt(input int i);
        return 32'(cnt[i*THR_W +: THR_W]);
    endfunction

    // Behavioural model: saturating counts, sticky alarms, one write per vld-low gap.
    int m_cnt  [NCH] = '{default: 0};
    bit m_ovr  [NCH] = '{default: 0};
    int m_thr  [NCH] = '{default: 0};
    bit m_ack   = 1'b0;
    bit m_armed = 1'b1;
    int m_since = 0;
    bit m_pend  = 1'b0;
    int m_pch   = 0;
    int m_pval  = 0;

    always @(posedge bist_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0;
                m_ovr[i] = 1'b0;
                m_thr[i] = 0;
            end
            m_ack = 1'b0; m_armed = 1'b1; m_since = 0; m_pend = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    m_cnt[i] = 0;
                    m_ovr[i] = 1'b0;
                end else begin
                    if (evt[i]) m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
                    if (m_thr[i] != 0 && m_cnt[i] >= m_thr[i]) m_ovr[i] = 1'b1;
                end
            end
            if (m_pend) begin
                if (m_pch < NCH) m_thr[m_pch] = m_pval;
                m_pend = 1'b0;
            end
            m_ack = 1'b0;
            if (!m_armed) begin
                m_since++;
                if (m_since >= 2 && !vld) m_armed = 1'b1;
            end else if (vld) begin
                m_armed = 1'b0;
                m_since = 0;
                m_pend  = 1'b1;
                m_pch   = int'(ch);
                m_pval  = int'(val);
                m_ack   = 1'b1;
            end
        end
    end

    always @(negedge bist_clk) begin
        logic [NCH-1:0] m_over_vec;
        m_over_vec = '0;
        chk("model_ack", 32'(ack), 32'(m_ack));
        for (int i = 0; i < NCH; i++) begin
            m_over_vec[i] = m_ovr[i];
            chk($sformatf("model_cnt%0d", i), dcnt(i), m_cnt[i]);
        end
        chk("model_over", 32'(over), 32'(m_over_vec));
        chk("model_irq", 32'(irq), 32'(|m_over_vec));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int acks;
        int hi_left;
        int lo_left;

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge bist_clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_over", 32'(over), 0);
        chk("rst_irq", 32'(irq), 0);
        reset_n = 1'b1;

        // Write ch2 thr=3, then three events reach it.
        @(negedge bist_clk);
        vld = 1'b1; ch = 2'd2; val = 8'd3;
        @(negedge bist_clk);
        chk("w32_ack", 32'(ack), 1);
        vld = 1'b0;
        @(negedge bist_clk);
        chk("w32_ack_once", 32'(ack), 0);
        evt = 3'b100;
        repeat (2) @(negedge bist_clk);
        chk("e32_cnt2_2", dcnt(2), 2);
        chk("e32_over_2", 32'(over), 0);
        @(negedge bist_clk);
        evt = '0;
        chk("e32_cnt2_3", dcnt(2), 3);
        chk("e32_over_3", 32'(over), 32'b100);
        chk("e32_irq", 32'(irq), 1);

        // vld held five cycles gives a single ack; re-accept after one low cycle.
        clr = 3'b100;
        @(negedge bist_clk);
        clr = '0;
        vld = 1'b1; ch = 2'd0; val = 8'd0;
        acks = 0;
        repeat (5) begin
            @(negedge bist_clk);
            acks += int'(ack);
        end
        chk("hold_acks", 32'(acks), 1);
        vld = 1'b0;
        @(negedge bist_clk);
        vld = 1'b1;
        @(negedge bist_clk);
        chk("rewrite_ack", 32'(ack), 1);
        vld = 1'b0;

        // Threshold 0 on ch0: saturate at 255 with no alarm.
        evt = 3'b001;
        repeat (300) @(negedge bist_clk);
        evt = '0;
        chk("sat_cnt0", dcnt(0), 255);
        chk("sat_over", 32'(over), 0);
        chk("sat_irq", 32'(irq), 0);

        // ch1 count 10, then thr=4 written: alarm two cycles after capture.
        evt = 3'b010;
        repeat (10) @(negedge bist_clk);
        evt = '0;
        chk("c35_cnt1", dcnt(1), 10);
        vld = 1'b1; ch = 2'd1; val = 8'd4;
        @(negedge bist_clk);
        chk("c35_ack", 32'(ack), 1);
        chk("c35_over_cap", 32'(over[1]), 0);
        vld = 1'b0;
        @(negedge bist_clk);
        chk("c35_over_eff", 32'(over[1]), 0);
        @(negedge bist_clk);
        chk("c35_over_set", 32'(over[1]), 1);
        evt = 3'b010; clr = 3'b010;
        @(negedge bist_clk);
        evt = '0; clr = '0;
        chk("c35_clr_cnt1", dcnt(1), 0);
        chk("c35_clr_over", 32'(over[1]), 0);
        chk("c35_clr_irq", 32'(irq), 0);

        // Out-of-range channel: acked, thresholds (0,4,3) intact.
        vld = 1'b1; ch = 2'd3; val = 8'd1;
        @(negedge bist_clk);
        chk("oor_ack", 32'(ack), 1);
        vld = 1'b0;
        repeat (2) @(negedge bist_clk);
        clr = 3'b111;
        @(negedge bist_clk);
        clr = '0; evt = 3'b111;
        @(negedge bist_clk);
        evt = '0;
        chk("oor_over_1", 32'(over), 0);
        evt = 3'b110;
        repeat (3) @(negedge bist_clk);
        evt = '0;
        chk("oor_over_4", 32'(over), 32'b110);

        // Reset during ACK aborts; vld still high afterwards is a fresh request.
        clr = 3'b111;
        @(negedge bist_clk);
        clr = '0;
        vld = 1'b1; ch = 2'd0; val = 8'd2;
        @(posedge bist_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ack_abort", 32'(ack), 0);
        chk("rst_over_abort", 32'(over), 0);
        @(negedge bist_clk);
        #1 reset_n = 1'b1;
        @(negedge bist_clk);
        chk("rst_reack", 32'(ack), 1);
        vld = 1'b0;
        @(negedge bist_clk);
        evt = 3'b001;
        repeat (2) @(negedge bist_clk);
        evt = '0;
        chk("rst_cnt0", dcnt(0), 2);
        chk("rst_over0", 32'(over[0]), 1);

        // Randomized traffic against the model.
        hi_left = 0;
        lo_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge bist_clk);
            if (hi_left > 0) begin
                hi_left--;
                if (hi_left == 0) begin
                    vld = 1'b0;
                    lo_left = $urandom_range(0, 2);
                end
            end else if (lo_left > 0) begin
                lo_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                vld = 1'b1;
                ch  = CH_W'($urandom_range(0, 3));
                val = ($urandom_range(0, 3) == 0) ? THR_W'($urandom) : THR_W'($urandom_range(0, 11));
                hi_left = $urandom_range(1, 5);
            end
            for (int i = 0; i < NCH; i++) begin
                evt[i] = ($urandom_range(0, 1) == 0);
                clr[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                @(posedge bist_clk);
                #2 reset_n = 1'b0;
                @(negedge bist_clk);
                #1 reset_n = 1'b1;
            end
        end
        evt = '0; clr = '0; vld = 1'b0;
        repeat (3) @(negedge bist_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cerr_thresh_ctrl.md
CERR_THRESH_CTRL -- requirements
Module: cerr_thresh_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent correctable-error channels, legal range 1..16.
REQ-002 Parameter THR_W, default 8: width of each threshold and each error counter.
REQ-003 Parameter CH_W, default 2: channel-select width, equal to max(1, clog2(NUM_CH)).
REQ-004 Parameter DEF_THR, default 0: threshold value loaded into every channel at reset (0 = alarm disabled).
REQ-005 bist_clk  in  1  sole clock; all state is updated on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cerr_threshold_vld  in  1  threshold write request, held high until acknowledged.
REQ-008 cerr_threshold_ch  in  CH_W  target channel of the write, stable while vld is high.
REQ-009 cerr_threshold  in  THR_W  threshold value, stable while vld is high.
REQ-010 cerr_threshold_ack  out  1  registered one-cycle acknowledge of a write.
REQ-011 cerr_evt  in  NUM_CH  per-channel correctable-error pulse, one event per cycle per bit.
REQ-012 cerr_clr  in  NUM_CH  per-channel synchronous clear of the counter and alarm.
REQ-013 cerr_count  out  NUM_CH*THR_W  per-channel counters; channel i occupies bits [i*THR_W +: THR_W].
REQ-014 cerr_over  out  NUM_CH  per-channel sticky threshold-reached flag.
REQ-015 cerr_irq  out  1  OR of all cerr_over bits.

Function
REQ-016 The write handshake shall use FSM states IDLE, ACK and HOLD.
- IDLE: when vld=1, capture ch/value and go to ACK.
- ACK: drive ack=1 for exactly one cycle, then go to HOLD.
- HOLD: stay until vld=0, then return to IDLE.
REQ-017 Ack latency shall be exactly 1 cycle from the capturing edge, and no second write shall be accepted until vld has been observed low.
REQ-018 A write with cerr_threshold_ch >= NUM_CH shall still be acknowledged and shall modify no state.
REQ-019 A written threshold shall take effect on the cycle after capture.
REQ-020 Each counter shall increment by 1 on cerr_evt[i] and saturate at 2^THR_W-1 without wrapping.
REQ-021 cerr_clr[i] shall set count[i]=0 and over[i]=0 next cycle; clear wins over a simultaneous event on the same channel.
REQ-022 over[i] shall be set in the same edge that the counter reaches the threshold, i.e. when thr[i]!=0 and the next count >= thr[i].
REQ-023 over[i] shall stay set (sticky) until cerr_clr[i], independent of later threshold writes.
REQ-024 Writing a nonzero threshold <= the current count[i] shall set over[i] on the cycle after the threshold takes effect.
REQ-025 A threshold of 0 shall disable alarm setting for that channel; counting shall continue.
REQ-026 cerr_irq shall be combinational OR of the registered cerr_over bits, with no added latency.
REQ-027 Channels shall be fully independent; simultaneous events, clears and a write on different channels shall all take effect in the same cycle.
REQ-028 A simultaneous threshold write and event on the same channel shall compare the post-increment count against the new threshold on the cycle the threshold takes effect.

Reset
REQ-029 While reset_n=0, the block shall hold FSM=IDLE, ack=0, all counters=0, all over=0, irq=0 and all thresholds=DEF_THR.
REQ-030 Reset asserted mid-handshake shall abort the write with no threshold update; if vld is still high after reset, it shall be treated as a new request.
REQ-031 The block shall leave reset synchronously to bist_clk, and the first capture shall occur no earlier than the first rising edge with reset_n=1.

Verification
REQ-032 Write ch=2 val=3, then 3 evt pulses on ch2 -> ack high exactly 1 cycle after capture; count2=3 and over[2]=1 on the 3rd event edge; irq=1.
REQ-033 Hold vld high 5 cycles -> exactly one ack pulse; a second write is accepted only after vld drops for >=1 cycle.
REQ-034 THR_W=8, ch0 thr=0, 300 events -> count0 saturates at 255; over[0] and irq stay 0.
REQ-035 ch1 count=10, write thr=4 -> over[1]=1 two cycles after capture; evt and clr in the same cycle on ch1 -> count1=0, over[1]=0.
REQ-036 Write to ch=3 with NUM_CH=3 -> ack pulse; all thresholds unchanged.
REQ-037 Assert reset_n=0 during the ACK state -> ack=0 immediately and threshold unchanged; after release with vld still high -> new capture and ack.
